// File: rtl/syn_aud_pkg.sv
// syn_aud_pkg: shared audio sample types, driver FSM states and default I2S timing
package syn_aud_pkg;
  localparam int PCM_W = 16;
  localparam int BCLK_DIV_DEF = 4;
  localparam int BCLK_PER_CH_DEF = 32;
  typedef logic signed [PCM_W-1:0] pcm_t;
  typedef struct packed {
    pcm_t lchnl;
    pcm_t rchnl;
  } pcm_pair_t;
  typedef enum logic {IDLE, RUN} drv_state_e;
endpackage

// File: rtl/syn_dac_bclk_gen.sv
// syn_dac_bclk_gen: divides clk down to the I2S bit clock and flags its edges
module syn_dac_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall,
  output logic rise
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic bclk_q, tc;
  always_comb begin
    tc = en && (div_cnt_q == DW'(BCLK_DIV - 1));
    div_cnt_d = !en || tc ? '0 : div_cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q <= en && (tc ? !bclk_q : bclk_q);
    end
  end
  assign bclk = bclk_q;
  assign fall = tc && bclk_q;
  assign rise = tc && !bclk_q;
endmodule

// File: rtl/syn_dac_i2s_drvr.sv
// syn_dac_i2s_drvr: I2S transmit driver for the WM8731 DAC serial port
// Defining SYN_DAC_DRVR_UFLOW_CNTR_EN adds the saturating uflow_cnt output
module syn_dac_i2s_drvr
  import syn_aud_pkg::*;
#(
  parameter int DATA_W = PCM_W,
  parameter int BCLK_DIV = BCLK_DIV_DEF,
  parameter int BCLK_PER_CH = BCLK_PER_CH_DEF
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              dac_en,
  input  logic              pcm_valid,
  output logic              pcm_ready,
  input  logic [DATA_W-1:0] pcm_lchnl,
  input  logic [DATA_W-1:0] pcm_rchnl,
  output logic              dac_mclk,
  output logic              dac_bclk,
  output logic              dac_lrc,
  output logic              dac_dat
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
  ,
  output logic [15:0]       uflow_cnt
`endif
);
  localparam int FRAME = 2 * BCLK_PER_CH;
  localparam int BW = $clog2(FRAME);
  drv_state_e state_q;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d, k;
  logic [2*DATA_W-1:0] word_q;
  logic [DATA_W-1:0] slot_word, sh;
  logic mclk_q, lrc_q, dat_q, ready_q, lrc_d, dat_d, wrap, bclk_fall, bclk_rise;
  syn_dac_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk(clk),
    .rst(sys_rst),
    .en(state_q == RUN),
    .bclk(dac_bclk),
    .fall(bclk_fall),
    .rise(bclk_rise)
  );
  // Slot bit k carries word bit DATA_W-k, giving the one-bclk I2S MSB delay
  always_comb begin
    wrap = bit_cnt_q == BW'(FRAME - 1);
    bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
    lrc_d = bit_cnt_d >= BW'(BCLK_PER_CH);
    k = lrc_d ? bit_cnt_d - BW'(BCLK_PER_CH) : bit_cnt_d;
    slot_word = lrc_d ? word_q[DATA_W-1:0] : word_q[2*DATA_W-1:DATA_W];
    sh = slot_word << (k - 1'b1);
    dat_d = k != '0 && k <= BW'(DATA_W) && sh[DATA_W-1];
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      word_q <= '0;
      mclk_q <= 1'b0;
      lrc_q <= 1'b0;
      dat_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      mclk_q <= !mclk_q;
      ready_q <= 1'b0;
      if (ready_q) word_q <= pcm_valid ? {pcm_lchnl, pcm_rchnl} : '0;
      if (state_q == IDLE) begin
        state_q <= dac_en ? RUN : IDLE;
        ready_q <= dac_en;
        bit_cnt_q <= '0;
      end else if (bclk_fall) begin
        bit_cnt_q <= bit_cnt_d;
        lrc_q <= lrc_d;
        dat_q <= dat_d;
        ready_q <= wrap && dac_en;
        state_q <= wrap && !dac_en ? IDLE : RUN;
      end
    end
  end
  always_comb assert (!bclk_rise || state_q == RUN);
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
  logic [15:0] uflow_q;
  always_ff @(posedge clk) begin
    if (sys_rst) uflow_q <= '0;
    else if (ready_q && !pcm_valid && uflow_q != 16'hFFFF) uflow_q <= uflow_q + 16'd1;
  end
  assign uflow_cnt = uflow_q;
`endif
  assign pcm_ready = ready_q;
  assign dac_mclk = mclk_q;
  assign dac_lrc = lrc_q;
  assign dac_dat = dat_q;
endmodule

// File: tb/tb_syn_dac_i2s_drvr.sv
// tb_syn_dac_i2s_drvr: scoreboard bench decoding the I2S stream of two driver configurations
module tb_syn_dac_i2s_drvr;
  typedef struct {
    logic [31:0] pair;
    bit fok;
  } obs_t;
  logic clk, rst, en, valid;
  logic [15:0] l, r;
  logic d_mclk, d_bclk, d_lrc, d_dat, d_ready;
  logic s_mclk, s_bclk, s_lrc, s_dat, s_ready;
  logic m_bclk, m_lrc, m_dat, m_ready;
  bit sel;
  int pass_cnt, chk_cnt, rd;
  logic [31:0] exp_q[$];
  obs_t obs_q[$];
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
  logic [15:0] d_uflow, s_uflow;
`endif

  syn_dac_i2s_drvr u_dut (
    .clk(clk), .sys_rst(rst), .dac_en(en), .pcm_valid(valid), .pcm_ready(d_ready),
    .pcm_lchnl(l), .pcm_rchnl(r), .dac_mclk(d_mclk), .dac_bclk(d_bclk),
    .dac_lrc(d_lrc), .dac_dat(d_dat)
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
    , .uflow_cnt(d_uflow)
`endif
  );
  syn_dac_i2s_drvr #(.DATA_W(16), .BCLK_DIV(1), .BCLK_PER_CH(17)) u_small (
    .clk(clk), .sys_rst(rst), .dac_en(en), .pcm_valid(valid), .pcm_ready(s_ready),
    .pcm_lchnl(l), .pcm_rchnl(r), .dac_mclk(s_mclk), .dac_bclk(s_bclk),
    .dac_lrc(s_lrc), .dac_dat(s_dat)
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
    , .uflow_cnt(s_uflow)
`endif
  );

  assign m_bclk = sel ? s_bclk : d_bclk;
  assign m_lrc = sel ? s_lrc : d_lrc;
  assign m_dat = sel ? s_dat : d_dat;
  assign m_ready = sel ? s_ready : d_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // I2S monitor: samples dat/lrc on bclk rising edges, one frame per ready pulse
  initial begin
    int idx, k, bpc;
    logic pb;
    logic [15:0] wl, wr;
    bit fok;
    obs_t o;
    idx = -2; pb = 1'b0; wl = '0; wr = '0; fok = 1'b0;
    forever begin
      @(negedge clk);
      bpc = sel ? 17 : 32;
      if (rst) idx = -2;
      else if (m_ready) begin
        idx = -1; fok = 1'b1; wl = '0; wr = '0;
      end
      if (!rst && m_bclk && !pb && idx >= -1) begin
        idx++;
        k = idx % bpc;
        if (m_lrc !== (idx >= bpc)) fok = 1'b0;
        if (k >= 1 && k <= 16) begin
          if (idx >= bpc) wr = {wr[14:0], m_dat};
          else wl = {wl[14:0], m_dat};
        end else if (m_dat !== 1'b0) fok = 1'b0;
        if (idx == 2 * bpc - 1) begin
          o.pair = {wl, wr}; o.fok = fok;
          obs_q.push_back(o);
          idx = -2;
        end
      end
      pb = m_bclk;
    end
  end

  task automatic wait_ready(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (m_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic get_obs(output logic [31:0] pair, output bit ok);
    pair = 'x; ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (obs_q.size() > rd) begin
        pair = obs_q[rd].pair; ok = obs_q[rd].fok; rd++;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic pm;
    int bad_m, bad_o;
    rst = 1'b1; en = 1'b0; valid = 1'b0; l = '0; r = '0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({d_mclk, d_bclk, d_lrc, d_dat, d_ready} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {d_mclk, d_bclk, d_lrc, d_dat, d_ready});
    else pass_cnt++;
    pm = d_mclk; bad_m = 0; bad_o = 0;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (d_mclk === pm) bad_m++;
      if ({d_bclk, d_lrc, d_dat, d_ready} !== 4'b0) bad_o++;
      pm = d_mclk;
    end
    chk_cnt++;
    if (bad_m != 0) $display("FAIL mclk_toggle: got %0d stuck cycles want 0", bad_m);
    else pass_cnt++;
    chk_cnt++;
    if (bad_o != 0) $display("FAIL idle_quiet: got %0d active cycles want 0", bad_o);
    else pass_cnt++;
  endtask

  task automatic test_frame();
    int n;
    logic d7;
    logic [31:0] p, e;
    bit ok;
    exp_q.push_back({16'hA5C3, 16'h0F81});
    l = 16'hA5C3; r = 16'h0F81; valid = 1'b1; en = 1'b1;
    wait_ready(10, n);
    chk_cnt++;
    if (n != 1) $display("FAIL entry_ready: got %0d cycles want 1", n);
    else pass_cnt++;
    repeat (7) @(negedge clk);
    d7 = d_dat;
    @(negedge clk);
    chk_cnt++;
    if ({d7, d_dat} !== 2'b01) $display("FAIL left_msb_delay: got %b want 01", {d7, d_dat});
    else pass_cnt++;
    valid = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    wait_ready(600, n);
    chk_cnt++;
    if (n != 504) $display("FAIL frame_period: got %0d want 512", n + 8);
    else pass_cnt++;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL frame_data: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    int n;
    logic [31:0] p, e;
    bit ok;
    @(negedge clk);
    wait_ready(600, n);
    chk_cnt++;
    if (n != 511) $display("FAIL uflow_ready2: got %0d want 511", n);
    else pass_cnt++;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL uflow_data1: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
    @(negedge clk);
    l = 16'h1234; r = 16'hBEEF; valid = 1'b1;
    exp_q.push_back({16'h1234, 16'hBEEF});
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
    chk_cnt++;
    if (d_uflow !== 16'd2) $display("FAIL uflow_cnt: got %0d want 2", d_uflow);
    else pass_cnt++;
`endif
    wait_ready(600, n);
    chk_cnt++;
    if (n != 511) $display("FAIL ready_after_uflow: got %0d want 511", n);
    else pass_cnt++;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL uflow_data2: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
  endtask

  task automatic test_disable();
    int bad_r, bad_o;
    logic [31:0] p, e;
    bit ok;
    repeat (100) @(negedge clk);
    en = 1'b0;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL disable_frame_data: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    bad_r = 0; bad_o = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (d_ready !== 1'b0) bad_r++;
      if ({d_bclk, d_lrc, d_dat} !== 3'b0) bad_o++;
    end
    chk_cnt++;
    if (bad_r != 0) $display("FAIL disable_no_ready: got %0d pulses want 0", bad_r);
    else pass_cnt++;
    chk_cnt++;
    if (bad_o != 0) $display("FAIL disable_idle_low: got %0d active cycles want 0", bad_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] p, e;
    bit ok;
    l = 16'h5A5A; r = 16'hC3C3; valid = 1'b1; en = 1'b1;
    wait_ready(10, n);
    chk_cnt++;
    if (n != 1) $display("FAIL reentry_ready: got %0d want 1", n);
    else pass_cnt++;
    repeat (322) @(negedge clk);
    chk_cnt++;
    if (d_lrc !== 1'b1) $display("FAIL lrc_right_slot: got %b want 1", d_lrc);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({d_mclk, d_bclk, d_lrc, d_dat, d_ready} !== 5'b0)
      $display("FAIL reset_mid_outputs: got %b want 00000", {d_mclk, d_bclk, d_lrc, d_dat, d_ready});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    exp_q.push_back({16'h5A5A, 16'hC3C3});
    rst = 1'b0;
    wait_ready(10, n);
    chk_cnt++;
    if (n != 1) $display("FAIL ready_after_reset: got %0d want 1", n);
    else pass_cnt++;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL reset_refill_data: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
    en = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_small();
    int n;
    logic [31:0] p, e;
    bit ok;
    sel = 1'b1;
    l = 16'h8000; r = 16'h7FFF; valid = 1'b1;
    exp_q.push_back({16'h8000, 16'h7FFF});
    en = 1'b1;
    wait_ready(10, n);
    chk_cnt++;
    if (n != 1) $display("FAIL small_entry: got %0d want 1", n);
    else pass_cnt++;
    @(negedge clk);
    wait_ready(100, n);
    chk_cnt++;
    if (n != 67) $display("FAIL small_period: got %0d want 68", n + 1);
    else pass_cnt++;
    get_obs(p, ok);
    e = exp_q.pop_front();
    chk_cnt++;
    if ({ok, p} !== {1'b1, e}) $display("FAIL small_data: got ok=%b %h want ok=1 %h", ok, p, e);
    else pass_cnt++;
`ifdef SYN_DAC_DRVR_UFLOW_CNTR_EN
    chk_cnt++;
    if (s_uflow !== 16'd0) $display("FAIL small_uflow: got %0d want 0", s_uflow);
    else pass_cnt++;
`endif
    en = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    pass_cnt = 0; chk_cnt = 0; rd = 0; sel = 1'b0;
    test_reset();
    test_frame();
    test_underflow();
    test_disable();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/syn_dac_i2s_drvr.md
# syn_dac_i2s_drvr

Transmit-side driver for the WM8731 DAC serial port. It accepts stereo PCM sample pairs from the upstream audio buffer through a valid/ready handshake and generates dac_mclk, dac_bclk, dac_lrc and dac_dat in I2S format. It sits directly upstream of the codec DAC pins; its outputs are the DUT_DAC modport signals checked by the TB_DAC monitor.

## Interface
- DATA_W, 16: PCM sample width per channel.
- BCLK_DIV, 4: bclk half-period in clk cycles (≥1).
- BCLK_PER_CH, 32: bclk periods per channel slot (≥ DATA_W+1).
- clk  in  1  system/audio clock; dac_mclk is derived from it.
- sys_rst  in  1  synchronous, active-high reset.
- dac_en  in  1  enable; sampled only at frame boundaries.
- pcm_valid  in  1  upstream sample pair available.
- pcm_ready  out  1  one-cycle accept strobe at frame start.
- pcm_lchnl  in  DATA_W  left sample, two's complement.
- pcm_rchnl  in  DATA_W  right sample, two's complement.
- dac_mclk  out  1  clk/2.
- dac_bclk  out  1  bit clock, clk/(2*BCLK_DIV).
- dac_lrc  out  1  0 = left slot, 1 = right slot.
- dac_dat  out  1  serial data, MSB first.
- uflow_cnt  out  16  underflow count (only with macro, see Configuration).

## Operation
- Reset: all outputs 0; all counters 0; FSM in IDLE.
- FSM states: IDLE, RUN.
- IDLE: dac_bclk, dac_lrc and dac_dat held 0. dac_mclk keeps toggling. When dac_en=1, go to RUN at the next clk. bit_cnt starts at 0 and a frame-start event occurs in the first RUN cycle.
- RUN: div_cnt counts 0..BCLK_DIV-1. At the terminal count, dac_bclk toggles.
  - On every bclk falling toggle (1→0), bit_cnt advances modulo 2*BCLK_PER_CH.
  - Wrap to 0 is a frame boundary.
- dac_lrc = (bit_cnt ≥ BCLK_PER_CH), registered on the falling toggle.
- Slot index k = bit_cnt mod BCLK_PER_CH.
  - dac_dat = word[DATA_W−k] for 1≤k≤DATA_W, otherwise 0.
  - word = latched left in the left slot, latched right in the right slot.
  - This gives the I2S one-bclk MSB delay.
- Frame start (RUN entry, or bit_cnt wrap):
  - pcm_ready pulses high for exactly that clk.
  - If pcm_valid=1: latch pcm_lchnl and pcm_rchnl.
  - Else (underflow): latch zeros.
- Frame boundary with dac_en=0: return to IDLE instead of starting a new frame. No ready pulse is issued. A partial frame is never truncated.
- Arithmetic: bit_cnt width is clog2(2*BCLK_PER_CH); div_cnt width is clog2(BCLK_DIV). Both wrap with no overflow state.

## Timing
- dac_mclk toggles every clk from the first cycle after reset release.
- Accept to left MSB on dac_dat: 2*BCLK_DIV clk.
- Accept to right MSB on dac_dat: (BCLK_PER_CH+1)*2*BCLK_DIV clk.
- Frame period: 4*BCLK_DIV*BCLK_PER_CH clk; default 512 clk.
- dac_dat and dac_lrc change only in the cycle of a bclk falling toggle. They are stable across the rising edge (codec sampling edge).
- Reset mid-frame: all outputs 0 in the next cycle. No pcm_ready is issued until the next RUN entry.
- pcm_valid deasserting while not at frame start has no effect.

## Configuration
- SYN_DAC_DRVR_UFLOW_CNTR_EN defined:
  - uflow_cnt port exists.
  - It increments by 1 on each underflow frame start, saturates at 0xFFFF, and is cleared by sys_rst.
- Not defined: port and counter are absent; underflow still outputs zeros.

## Structure
- Shared package syn_aud_pkg holds:
  - the PCM sample typedef (DATA_W-bit signed);
  - the stereo pair struct {lchnl, rchnl};
  - the driver FSM enum (IDLE, RUN);
  - the default BCLK_DIV and BCLK_PER_CH constants.
- One natural sub-module: syn_dac_bclk_gen. It contains div_cnt, dac_bclk, and fall/rise strobes. The top-level keeps the FSM, bit_cnt, latch and serializer.

## Test plan
- Reset release, dac_en=0 → dac_mclk toggles every clk; bclk, lrc, dat and ready remain 0 for 1000 clk.
- dac_en=1, pcm_valid=1, L=0xA5C3, R=0x0F81 → TB_DAC monitor decodes L=0xA5C3, R=0x0F81; frame = 512 clk; left MSB 8 clk after ready.
- Hold pcm_valid=0 for two frames → dac_dat=0 for both frames; ready pulses twice; uflow_cnt=2 with macro defined.
- Deassert dac_en mid-left-slot → current frame completes including the right slot, then outputs go idle low; no further ready.
- Assert sys_rst at bit_cnt=40 → next cycle all outputs 0; after re-enable, first ready appears in the first RUN cycle.
- BCLK_DIV=1, BCLK_PER_CH=17, DATA_W=16, L=0x8000, R=0x7FFF → frame = 68 clk; right slot k=1 is 0, k=2..16 are 1.
